// File: rtl/tt_mux_sel_rx_pkg.sv
// Shared definitions for the mux select receiver: FSM state encoding and synchronizer depth.
package tt_mux_sel_rx_pkg;

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_COUNT   = 2'd1,
    S_ENABLED = 2'd2
  } sel_state_e;

  localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/tt_mux_sel_rx_if.sv
// Mux control pulse inputs and registered spine outputs of the select receiver.
interface tt_mux_sel_rx_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              ctrl_sel_rst_n;
  logic              ctrl_sel_inc;
  logic              ctrl_ena;
  logic [ADDR_W-1:0] spine_sel;
  logic              spine_ena;
  logic              sel_busy;
  logic              sel_wrap;
  logic              sel_err;

  modport master (
    output ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena,
    input  spine_sel, spine_ena, sel_busy, sel_wrap, sel_err
  );

  modport slave (
    input  ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena,
    output spine_sel, spine_ena, sel_busy, sel_wrap, sel_err
  );
endinterface

// File: rtl/tt_mux_sel_rx_sync.sv
// Per-input synchronizer, history flop and rise detector for one mux control line.
// TT_MUX_SEL_FILTER_EN adds a stability filter between synchronizer and edge detect.
module tt_mux_sel_sync
  import tt_mux_sel_rx_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_DEPTH-1:0] sync_r;
  logic                  hist_r;
  logic                  raw_s;
  logic                  stable_s;

  // Metastability chain for an input asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_DEPTH-2:0], din};
    end
  end

  assign raw_s = sync_r[SYNC_DEPTH-1];

`ifdef TT_MUX_SEL_FILTER_EN
  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [CNT_W-1:0] cnt_r;
  logic             filt_r;

  // Accept a new level only after it has differed from the filtered one for FILTER_LEN cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      filt_r <= 1'b0;
    end else if (raw_s == filt_r) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_W'(FILTER_LEN - 1)) begin
      cnt_r  <= '0;
      filt_r <= raw_s;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign stable_s = filt_r;
`else
  localparam int unsigned unused_filter_len = FILTER_LEN;

  assign stable_s = raw_s;
`endif

  // One-cycle-old copy of the accepted level for rise detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_r <= 1'b0;
    end else begin
      hist_r <= stable_s;
    end
  end

  assign level = stable_s;
  assign rise  = stable_s & ~hist_r;

endmodule

// File: rtl/tt_mux_sel_rx.sv
// Receiver for the sel_rst_n / sel_inc / ena pulse protocol; drives the spine address and enable.
// Optional input stability filter: define TT_MUX_SEL_FILTER_EN.
module tt_mux_sel_rx
  import tt_mux_sel_rx_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned N_PROJ     = 1024,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tt_mux_sel_rx_if.slave         bus
);

  localparam logic [ADDR_W-1:0] SEL_LAST = ADDR_W'(N_PROJ - 1);

  logic              rst_lvl_s, ena_lvl_s, inc_edge_s;
  logic              rst_rise_unused_s, ena_rise_unused_s, inc_lvl_unused_s;
  sel_state_e        state_r, state_s;
  logic [ADDR_W-1:0] sel_r, sel_s;
  logic              ena_r, ena_s, busy_r, busy_s, wrap_r, wrap_s, err_r, err_s;

  tt_mux_sel_sync #(.FILTER_LEN(FILTER_LEN)) u_sync_rst (
    .clk(clk), .rst_n(rst_n), .din(bus.ctrl_sel_rst_n), .level(rst_lvl_s), .rise(rst_rise_unused_s)
  );
  tt_mux_sel_sync #(.FILTER_LEN(FILTER_LEN)) u_sync_inc (
    .clk(clk), .rst_n(rst_n), .din(bus.ctrl_sel_inc), .level(inc_lvl_unused_s), .rise(inc_edge_s)
  );
  tt_mux_sel_sync #(.FILTER_LEN(FILTER_LEN)) u_sync_ena (
    .clk(clk), .rst_n(rst_n), .din(bus.ctrl_ena), .level(ena_lvl_s), .rise(ena_rise_unused_s)
  );

  // Next-state and next-output logic; select reset overrides inc and ena.
  always_comb begin
    state_s = state_r;
    sel_s   = sel_r;
    ena_s   = ena_r;
    wrap_s  = wrap_r;
    err_s   = err_r;
    if (!rst_lvl_s) begin
      state_s = S_HOLD;
      sel_s   = '0;
      ena_s   = 1'b0;
      wrap_s  = 1'b0;
      err_s   = 1'b0;
    end else begin
      case (state_r)
        S_HOLD: begin
          state_s = S_COUNT;
          sel_s   = '0;
          ena_s   = 1'b0;
          wrap_s  = 1'b0;
          err_s   = 1'b0;
        end
        S_COUNT: begin
          // Increment lands before a coincident enable, so the enabled address is the new one.
          if (inc_edge_s) begin
            if (sel_r == SEL_LAST) begin
              sel_s  = '0;
              wrap_s = 1'b1;
            end else begin
              sel_s = sel_r + ADDR_W'(1);
            end
          end else begin
            sel_s = sel_r;
          end
          if (ena_lvl_s) begin
            state_s = S_ENABLED;
            ena_s   = 1'b1;
          end else begin
            state_s = S_COUNT;
            ena_s   = 1'b0;
          end
        end
        S_ENABLED: begin
          if (inc_edge_s) begin
            err_s = 1'b1;
          end else begin
            err_s = err_r;
          end
          if (!ena_lvl_s) begin
            state_s = S_COUNT;
            ena_s   = 1'b0;
          end else begin
            state_s = S_ENABLED;
            ena_s   = 1'b1;
          end
        end
        default: begin
          state_s = S_HOLD;
          sel_s   = '0;
          ena_s   = 1'b0;
          wrap_s  = 1'b0;
          err_s   = 1'b0;
        end
      endcase
    end
    busy_s = (state_s != S_ENABLED);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_HOLD;
      sel_r   <= '0;
      ena_r   <= 1'b0;
      busy_r  <= 1'b1;
      wrap_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      sel_r   <= sel_s;
      ena_r   <= ena_s;
      busy_r  <= busy_s;
      wrap_r  <= wrap_s;
      err_r   <= err_s;
    end
  end

  assign bus.spine_sel = sel_r;
  assign bus.spine_ena = ena_r;
  assign bus.sel_busy  = busy_r;
  assign bus.sel_wrap  = wrap_r;
  assign bus.sel_err   = err_r;

endmodule

// File: tb/tb_tt_mux_sel_rx.sv
// Self-checking bench for tt_mux_sel_rx: directed scenarios plus random ops against a behavioural model.
module tb_tt_mux_sel_rx;

  localparam int AW = 4;
  localparam int NP = 8;
  localparam int FL = 3;
`ifdef TT_MUX_SEL_FILTER_EN
  localparam int LAT = 3 + FL;
  localparam int PW  = FL + 1;
`else
  localparam int LAT = 3;
  localparam int PW  = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_total = 0;
  int n_bad = 0;

  // behavioural model: address, sticky flags, and pad levels
  int m_sel = 0;
  bit m_wrap = 1'b0, m_err = 1'b0, m_hold = 1'b1, m_ena = 1'b0;

  tt_mux_sel_rx_if #(.ADDR_W(AW)) bus ();

  tt_mux_sel_rx #(.ADDR_W(AW), .N_PROJ(NP), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle();
    repeat (LAT + 2) tick();
  endtask

  // one increment request at the pad, and its effect on the model
  task automatic pulse_inc();
    bus.ctrl_sel_inc = 1'b1;
    repeat (PW) tick();
    bus.ctrl_sel_inc = 1'b0;
    repeat (PW) tick();
    if (!m_hold) begin
      if (m_ena) m_err = 1'b1;
      else begin
        if (m_sel == NP - 1) m_wrap = 1'b1;
        m_sel = (m_sel + 1) % NP;
      end
    end
  endtask

  task automatic set_sel_rst(input bit v);
    bus.ctrl_sel_rst_n = v;
    m_hold = !v;
    if (!v) begin
      m_sel = 0; m_wrap = 1'b0; m_err = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.ctrl_sel_rst_n = 1'b0; bus.ctrl_sel_inc = 1'b0; bus.ctrl_ena = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    n_total++; if (bus.spine_sel !== 4'd0) begin n_bad++; $display("FAIL rst_sel got=%0d exp=0", bus.spine_sel); end
    n_total++; if (bus.spine_ena !== 1'b0) begin n_bad++; $display("FAIL rst_ena got=%b exp=0", bus.spine_ena); end
    n_total++; if (bus.sel_busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy got=%b exp=1", bus.sel_busy); end
    n_total++; if ({bus.sel_wrap, bus.sel_err} !== 2'b00) begin n_bad++; $display("FAIL rst_flags got=%b%b exp=00", bus.sel_wrap, bus.sel_err); end
    rst_n = 1'b1;
    pulse_inc();
    settle();
    n_total++; if (bus.spine_sel !== 4'd0) begin n_bad++; $display("FAIL hold_ignores_inc got=%0d exp=0", bus.spine_sel); end
  endtask

  task automatic test_count_enable();
    set_sel_rst(1'b1);
    settle();
    repeat (5) pulse_inc();
    settle();
    n_total++; if (bus.spine_sel !== AW'(m_sel)) begin n_bad++; $display("FAIL count5 got=%0d exp=%0d", bus.spine_sel, m_sel); end
    n_total++; if (bus.sel_busy !== 1'b1) begin n_bad++; $display("FAIL count_busy got=%b exp=1", bus.sel_busy); end
    bus.ctrl_ena = 1'b1; m_ena = 1'b1;
    repeat (LAT - 1) tick();
    n_total++; if (bus.spine_ena !== 1'b0) begin n_bad++; $display("FAIL ena_early got=%b exp=0", bus.spine_ena); end
    tick();
    n_total++; if (bus.spine_ena !== 1'b1) begin n_bad++; $display("FAIL ena_lat got=%b exp=1", bus.spine_ena); end
    n_total++; if (bus.sel_busy !== 1'b0) begin n_bad++; $display("FAIL ena_busy got=%b exp=0", bus.sel_busy); end
    n_total++; if (bus.spine_sel !== 4'd5) begin n_bad++; $display("FAIL ena_sel got=%0d exp=5", bus.spine_sel); end
    bus.ctrl_ena = 1'b0; m_ena = 1'b0;
    repeat (LAT - 1) tick();
    n_total++; if (bus.spine_ena !== 1'b1) begin n_bad++; $display("FAIL dis_early got=%b exp=1", bus.spine_ena); end
    tick();
    n_total++; if (bus.spine_ena !== 1'b0) begin n_bad++; $display("FAIL dis_lat got=%b exp=0", bus.spine_ena); end
  endtask

  task automatic test_err();
    set_sel_rst(1'b0); settle(); set_sel_rst(1'b1); settle();
    repeat (3) pulse_inc();
    bus.ctrl_ena = 1'b1; m_ena = 1'b1;
    settle();
    repeat (2) pulse_inc();
    settle();
    n_total++; if (bus.spine_sel !== 4'd3) begin n_bad++; $display("FAIL frozen_sel got=%0d exp=3", bus.spine_sel); end
    n_total++; if (bus.sel_err !== 1'b1) begin n_bad++; $display("FAIL err_set got=%b exp=1", bus.sel_err); end
    bus.ctrl_ena = 1'b0; m_ena = 1'b0;
    settle();
    pulse_inc();
    settle();
    n_total++; if (bus.spine_sel !== 4'd4) begin n_bad++; $display("FAIL resume_sel got=%0d exp=4", bus.spine_sel); end
    n_total++; if (bus.spine_ena !== 1'b0) begin n_bad++; $display("FAIL resume_ena got=%b exp=0", bus.spine_ena); end
    n_total++; if (bus.sel_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got=%b exp=1", bus.sel_err); end
  endtask

  task automatic test_wrap();
    set_sel_rst(1'b0); settle();
    n_total++; if ({bus.sel_wrap, bus.sel_err} !== 2'b00) begin n_bad++; $display("FAIL hold_clears got=%b%b exp=00", bus.sel_wrap, bus.sel_err); end
    set_sel_rst(1'b1); settle();
    repeat (NP + 1) pulse_inc();
    settle();
    n_total++; if (bus.spine_sel !== 4'd1) begin n_bad++; $display("FAIL wrap_sel got=%0d exp=1", bus.spine_sel); end
    n_total++; if (bus.sel_wrap !== 1'b1) begin n_bad++; $display("FAIL wrap_flag got=%b exp=1", bus.sel_wrap); end
    set_sel_rst(1'b0); settle();
    n_total++; if (bus.spine_sel !== 4'd0) begin n_bad++; $display("FAIL wrap_clr_sel got=%0d exp=0", bus.spine_sel); end
    n_total++; if (bus.sel_wrap !== 1'b0) begin n_bad++; $display("FAIL wrap_clr got=%b exp=0", bus.sel_wrap); end
  endtask

  task automatic test_coincident();
    set_sel_rst(1'b1); settle();
    repeat (6) pulse_inc();
    settle();
    bus.ctrl_sel_inc = 1'b1; bus.ctrl_ena = 1'b1;
    repeat (PW) tick();
    bus.ctrl_sel_inc = 1'b0;
    settle();
    n_total++; if (bus.spine_sel !== 4'd7) begin n_bad++; $display("FAIL coinc_sel got=%0d exp=7", bus.spine_sel); end
    n_total++; if (bus.spine_ena !== 1'b1) begin n_bad++; $display("FAIL coinc_ena got=%b exp=1", bus.spine_ena); end
    n_total++; if (bus.sel_err !== 1'b0) begin n_bad++; $display("FAIL coinc_err got=%b exp=0", bus.sel_err); end
    bus.ctrl_ena = 1'b0;
    m_sel = 7; m_ena = 1'b0;
    settle();
  endtask

  task automatic test_async_reset();
    repeat (2) pulse_inc();
    bus.ctrl_sel_inc = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (bus.spine_sel !== 4'd0) begin n_bad++; $display("FAIL arst_sel got=%0d exp=0", bus.spine_sel); end
    n_total++; if (bus.sel_busy !== 1'b1) begin n_bad++; $display("FAIL arst_busy got=%b exp=1", bus.sel_busy); end
    n_total++; if ({bus.spine_ena, bus.sel_wrap, bus.sel_err} !== 3'b000) begin n_bad++; $display("FAIL arst_flags got=%b exp=000", {bus.spine_ena, bus.sel_wrap, bus.sel_err}); end
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    m_sel = 0; m_wrap = 1'b0; m_err = 1'b0; m_hold = 1'b0;
    settle();
    n_total++; if (bus.spine_sel !== 4'd0) begin n_bad++; $display("FAIL arst_spurious got=%0d exp=0", bus.spine_sel); end
    bus.ctrl_sel_inc = 1'b0;
    settle();
    pulse_inc();
    settle();
    n_total++; if (bus.spine_sel !== AW'(m_sel)) begin n_bad++; $display("FAIL arst_resume got=%0d exp=%0d", bus.spine_sel, m_sel); end
  endtask

`ifdef TT_MUX_SEL_FILTER_EN
  task automatic test_filter();
    int base;
    base = m_sel;
    bus.ctrl_sel_inc = 1'b1;
    repeat (FL - 1) tick();
    bus.ctrl_sel_inc = 1'b0;
    settle();
    n_total++; if (bus.spine_sel !== AW'(base)) begin n_bad++; $display("FAIL glitch got=%0d exp=%0d", bus.spine_sel, base); end
    pulse_inc();
    settle();
    n_total++; if (bus.spine_sel !== AW'((base + 1) % NP)) begin n_bad++; $display("FAIL filt_pulse got=%0d exp=%0d", bus.spine_sel, (base + 1) % NP); end
  endtask
`endif

  task automatic test_random();
    int op;
    bit en_exp;
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 5) begin
        repeat ($urandom_range(1, 4)) pulse_inc();
      end else if (op <= 7) begin
        m_ena = !m_ena;
        bus.ctrl_ena = m_ena;
      end else begin
        set_sel_rst(m_hold);
      end
      settle();
      en_exp = !m_hold && m_ena;
      n_total++; if (bus.spine_sel !== AW'(m_sel)) begin n_bad++; $display("FAIL rnd_sel it=%0d got=%0d exp=%0d", it, bus.spine_sel, m_sel); end
      n_total++; if (bus.spine_ena !== en_exp) begin n_bad++; $display("FAIL rnd_ena it=%0d got=%b exp=%b", it, bus.spine_ena, en_exp); end
      n_total++; if (bus.sel_busy !== !en_exp) begin n_bad++; $display("FAIL rnd_busy it=%0d got=%b exp=%b", it, bus.sel_busy, !en_exp); end
      n_total++; if (bus.sel_wrap !== m_wrap) begin n_bad++; $display("FAIL rnd_wrap it=%0d got=%b exp=%b", it, bus.sel_wrap, m_wrap); end
      n_total++; if (bus.sel_err !== m_err) begin n_bad++; $display("FAIL rnd_err it=%0d got=%b exp=%b", it, bus.sel_err, m_err); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_count_enable();
    test_err();
    test_wrap();
    test_coincident();
    test_async_reset();
`ifdef TT_MUX_SEL_FILTER_EN
    test_filter();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
